ps2_key_decoder: RTL
====================

// Module: ps2_key_decoder
// PURPOSE
//  Receives the raw PS/2 keyboard stream (ps2Clk/ps2Data) and turns make codes into the 4-bit
//  command codes consumed by the input-decode stage. Sits directly upstream of that stage.
//  Emits one command per key press as a single-cycle pulse on inCode.
//  inCode is held at IDLE_CODE at all other times. Break (release) codes never produce output.
// PARAMETERS
//  TIMEOUT_CYCLES  50000  clock cycles without a ps2Clk fall mid-frame before the frame is aborted (1 ms @ 50 MHz)
//  SYNC_STAGES     2      flip-flop stages on ps2Clk and on ps2Data (minimum 2)
//  IDLE_CODE       4'hF   inCode value when no command is issued (no-op downstream)
// PORTS
//  clock       in   1  system clock
//  reset       in   1  asynchronous, active-low reset
//  ps2Clk      in   1  PS/2 clock from keyboard, asynchronous to clock
//  ps2Data     in   1  PS/2 data from keyboard, asynchronous to clock
//  inCode      out  4  command code; valid for 1 cycle, otherwise IDLE_CODE
//  codeValid   out  1  1-cycle pulse coincident with a non-idle inCode
//  frameError  out  1  1-cycle pulse on a parity, start or stop error, or on a timeout abort
//  scanByte    out  8  last correctly received byte (debug); holds its value until the next good frame
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-low.
//  Reset values: inCode=IDLE_CODE, codeValid=0, frameError=0, scanByte=8'h00. All FSMs return to
//   IDLE and the ext/brk flags are cleared. Reset mid-frame discards the partial frame.
//  Sync and edge detect: ps2Clk and ps2Data each pass through SYNC_STAGES FFs.
//   A fall = synced ps2Clk was 1 last cycle and is 0 now. ps2Data (synced) is sampled only in a fall cycle.
//  Frame FSM (bit level):
//   IDLE   -> on a fall: if data==0, go to DATA with bitCnt=0; if data==1, flag a start error.
//   DATA   -> shift 8 bits, LSB first, bitCnt 0..7; after bit 7 go to PARITY.
//   PARITY -> capture the parity bit; go to STOP.
//   STOP   -> capture the stop bit; go to IDLE.
//    The frame is good only if stop==1 and ^{data,parity}==1 (odd parity).
//   Timeout: in DATA/PARITY/STOP, a cycle counter resets on every fall.
//    When it reaches TIMEOUT_CYCLES: go to IDLE and pulse frameError.
//  Byte FSM (protocol level), run once per good frame; flags ext, brk:
//   8'hE0 -> ext=1.  8'hF0 -> brk=1.
//   Any other byte with brk=1 -> clear ext and brk; no output.
//   Any other byte with brk=0 -> look it up using ext; emit if mapped; clear ext.
//   Bad frame -> clear ext and brk; pulse frameError; no output.
//  Map, non-extended: 45->0, 16->1, 1E->2, 26->3, 2D(R)->4, 34(G)->5, 32(B)->6,
//   79(KP+)->B, 7B(KP-)->C, 2B(F)->D.
//  Map, extended: E0 75(up)->7, E0 72(down)->8, E0 6B(left)->9, E0 74(right)->A.
//   Non-extended 75/72/6B/74 (keypad digits) are unmapped. Unmapped bytes are ignored silently.
//  Latency: the stop-bit fall is seen in cycle N. scanByte updates at N+1.
//   inCode/codeValid are asserted for exactly cycle N+1 and return to IDLE_CODE at N+2.
//  Typematic repeat (the same make code sent again) produces a new pulse each time; this is intended.
//  A new fall can arrive no sooner than about 30 us later, so back-to-back outputs never overlap.
//  frameError and codeValid are never asserted in the same cycle.
// STRUCTURE
//  Include file ps2_codes.vh: localparams for the PS/2 bytes (E0, F0, the key make codes)
//   and the 4-bit command codes (CMD_NUM0..CMD_FLASH, CMD_IDLE).
//   The input-decode stage includes the same file.
//  Sub-module ps2_frame_rx: sync, edge detect, frame FSM and timeout.
//   Outputs byteOut[7:0], byteStrobe, byteErr.
//  Top level: byte FSM, ext/brk flags, combinational map, registered outputs.
// TESTING
//  1 Frame for 8'h2D (bits LSB first, parity 1, stop 1) -> inCode=4'h4, codeValid=1 for exactly 1 cycle; scanByte=8'h2D.
//  2 E0,75 then E0,F0,75 -> exactly one pulse, inCode=4'h7; the release produces nothing; ext and brk end at 0.
//  3 Byte 8'h75 without E0 -> no pulse; inCode stays at 4'hF.
//  4 Frame 8'h16 with wrong parity -> frameError pulse, no codeValid. Next good 8'h16 -> inCode=4'h1.
//  5 Stop after 4 data bits, wait TIMEOUT_CYCLES+10 -> frameError pulse. Then a full 8'h1E frame -> inCode=4'h2.
//  6 Assert reset low in the middle of bit 5 of a frame -> all outputs at reset values immediately.
//    After release, the next complete frame decodes normally.

Source files
------------

// File: rtl/ps2_key_decoder_pkg.sv
// +----------------------------------------------------------------------------+
// | ps2_key_decoder_pkg : PS/2 byte values, command codes, FSM types, key map   |
// | Revision 1.0                                                                |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

package ps2_key_decoder_pkg;

    localparam logic [7:0] KEY_EXT   = 8'hE0;
    localparam logic [7:0] KEY_BRK   = 8'hF0;
    localparam logic [7:0] KEY_NUM0  = 8'h45;
    localparam logic [7:0] KEY_NUM1  = 8'h16;
    localparam logic [7:0] KEY_NUM2  = 8'h1E;
    localparam logic [7:0] KEY_NUM3  = 8'h26;
    localparam logic [7:0] KEY_RED   = 8'h2D;
    localparam logic [7:0] KEY_GREEN = 8'h34;
    localparam logic [7:0] KEY_BLUE  = 8'h32;
    localparam logic [7:0] KEY_PLUS  = 8'h79;
    localparam logic [7:0] KEY_MINUS = 8'h7B;
    localparam logic [7:0] KEY_FLASH = 8'h2B;
    localparam logic [7:0] KEY_UP    = 8'h75;
    localparam logic [7:0] KEY_DOWN  = 8'h72;
    localparam logic [7:0] KEY_LEFT  = 8'h6B;
    localparam logic [7:0] KEY_RIGHT = 8'h74;

    localparam logic [3:0] CMD_NUM0  = 4'h0;
    localparam logic [3:0] CMD_NUM1  = 4'h1;
    localparam logic [3:0] CMD_NUM2  = 4'h2;
    localparam logic [3:0] CMD_NUM3  = 4'h3;
    localparam logic [3:0] CMD_RED   = 4'h4;
    localparam logic [3:0] CMD_GREEN = 4'h5;
    localparam logic [3:0] CMD_BLUE  = 4'h6;
    localparam logic [3:0] CMD_UP    = 4'h7;
    localparam logic [3:0] CMD_DOWN  = 4'h8;
    localparam logic [3:0] CMD_LEFT  = 4'h9;
    localparam logic [3:0] CMD_RIGHT = 4'hA;
    localparam logic [3:0] CMD_PLUS  = 4'hB;
    localparam logic [3:0] CMD_MINUS = 4'hC;
    localparam logic [3:0] CMD_FLASH = 4'hD;
    localparam logic [3:0] CMD_IDLE  = 4'hF;

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } rx_state_t;

    // Bit 0 carries the extended flag, bit 1 the break flag.
    typedef enum logic [1:0] {
        PROTO_BASE    = 2'd0,
        PROTO_EXT     = 2'd1,
        PROTO_BRK     = 2'd2,
        PROTO_EXT_BRK = 2'd3
    } proto_state_t;

    typedef struct packed {
        logic       hit;
        logic [3:0] cmd;
    } map_t;

    function automatic map_t map_key(input logic [7:0] code, input logic ext);
        map_t m;
        m.hit = 1'b1;
        m.cmd = CMD_IDLE;
        if (ext) begin
            case (code)
                KEY_UP:    m.cmd = CMD_UP;
                KEY_DOWN:  m.cmd = CMD_DOWN;
                KEY_LEFT:  m.cmd = CMD_LEFT;
                KEY_RIGHT: m.cmd = CMD_RIGHT;
                default:   m.hit = 1'b0;
            endcase
        end else begin
            case (code)
                KEY_NUM0:  m.cmd = CMD_NUM0;
                KEY_NUM1:  m.cmd = CMD_NUM1;
                KEY_NUM2:  m.cmd = CMD_NUM2;
                KEY_NUM3:  m.cmd = CMD_NUM3;
                KEY_RED:   m.cmd = CMD_RED;
                KEY_GREEN: m.cmd = CMD_GREEN;
                KEY_BLUE:  m.cmd = CMD_BLUE;
                KEY_PLUS:  m.cmd = CMD_PLUS;
                KEY_MINUS: m.cmd = CMD_MINUS;
                KEY_FLASH: m.cmd = CMD_FLASH;
                default:   m.hit = 1'b0;
            endcase
        end
        return m;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_key_decoder_frame_rx.sv
// +----------------------------------------------------------------------------+
// | ps2_frame_rx : PS/2 line sync, clock-fall detect, 11-bit frame FSM, timeout |
// | Revision 1.0                                                                |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module ps2_frame_rx
    import ps2_key_decoder_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2Clk,
    input  logic       ps2Data,
    output logic [7:0] byteOut,
    output logic       byteStrobe,
    output logic       byteErr
);

    localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int CNT_W  = $clog2(TIMEOUT_CYCLES + 1);

    logic [SYNC_N-1:0] clk_sync;
    logic [SYNC_N-1:0] data_sync;
    logic              clk_prev;
    logic              fall;
    logic              bit_in;

    rx_state_t         state;
    rx_state_t         state_next;
    logic [2:0]        bit_cnt;
    logic [7:0]        shift;
    logic              parity_bit;
    logic [CNT_W-1:0]  tmo_cnt;
    logic              timeout;

    // Lines idle high, so the synchronisers reset to 1 to avoid a false fall.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_N-2:0], ps2Clk};
            data_sync <= {data_sync[SYNC_N-2:0], ps2Data};
            clk_prev  <= clk_sync[SYNC_N-1];
        end
    end

    assign fall    = clk_prev & ~clk_sync[SYNC_N-1];
    assign bit_in  = data_sync[SYNC_N-1];
    assign timeout = (state != RX_IDLE) && !fall && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES));
    assign byteOut = shift;

    always_comb begin
        state_next = state;
        byteStrobe = 1'b0;
        byteErr    = 1'b0;
        case (state)
            RX_IDLE: begin
                if (fall) begin
                    if (!bit_in) state_next = RX_DATA;
                    else         byteErr    = 1'b1;
                end
            end
            RX_DATA: begin
                if (fall && (bit_cnt == 3'd7)) state_next = RX_PARITY;
            end
            RX_PARITY: begin
                if (fall) state_next = RX_STOP;
            end
            RX_STOP: begin
                if (fall) begin
                    state_next = RX_IDLE;
                    if (bit_in && (^{shift, parity_bit})) byteStrobe = 1'b1;
                    else                                  byteErr    = 1'b1;
                end
            end
            default: state_next = RX_IDLE;
        endcase
        if (timeout) begin
            state_next = RX_IDLE;
            byteErr    = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= RX_IDLE;
            bit_cnt    <= 3'd0;
            shift      <= 8'h00;
            parity_bit <= 1'b0;
            tmo_cnt    <= '0;
        end else begin
            state <= state_next;
            if (fall) begin
                case (state)
                    RX_IDLE:   bit_cnt <= 3'd0;
                    RX_DATA: begin
                        shift   <= {bit_in, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                    RX_PARITY: parity_bit <= bit_in;
                    default:   ;
                endcase
            end
            if ((state == RX_IDLE) || fall || timeout) tmo_cnt <= '0;
            else                                       tmo_cnt <= tmo_cnt + CNT_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/ps2_key_decoder.sv
// +----------------------------------------------------------------------------+
// | ps2_key_decoder : PS/2 make codes to 4-bit command pulses                   |
// | Revision 1.0                                                                |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module ps2_key_decoder
    import ps2_key_decoder_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 50000,
    parameter int         SYNC_STAGES    = 2,
    parameter logic [3:0] IDLE_CODE      = 4'hF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2Clk,
    input  logic       ps2Data,
    output logic [3:0] inCode,
    output logic       codeValid,
    output logic       frameError,
    output logic [7:0] scanByte
);

    logic [7:0]   rx_byte;
    logic         rx_strobe;
    logic         rx_err;

    proto_state_t state;
    proto_state_t state_next;
    logic         ext;
    logic         brk;
    map_t         lookup;
    logic         emit;

    ps2_frame_rx #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .SYNC_STAGES    (SYNC_STAGES)
    ) u_frame_rx (
        .clock      (clock),
        .reset      (reset),
        .ps2Clk     (ps2Clk),
        .ps2Data    (ps2Data),
        .byteOut    (rx_byte),
        .byteStrobe (rx_strobe),
        .byteErr    (rx_err)
    );

    assign ext    = (state == PROTO_EXT) || (state == PROTO_EXT_BRK);
    assign brk    = (state == PROTO_BRK) || (state == PROTO_EXT_BRK);
    assign lookup = map_key(rx_byte, ext);

    always_comb begin
        state_next = state;
        emit       = 1'b0;
        if (rx_err) begin
            state_next = PROTO_BASE;
        end else if (rx_strobe) begin
            if (rx_byte == KEY_EXT) begin
                state_next = brk ? PROTO_EXT_BRK : PROTO_EXT;
            end else if (rx_byte == KEY_BRK) begin
                state_next = ext ? PROTO_EXT_BRK : PROTO_BRK;
            end else begin
                // Any terminal byte ends the sequence; only unbroken mapped makes emit.
                state_next = PROTO_BASE;
                emit       = !brk && lookup.hit;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= PROTO_BASE;
            inCode     <= IDLE_CODE;
            codeValid  <= 1'b0;
            frameError <= 1'b0;
            scanByte   <= 8'h00;
        end else begin
            state      <= state_next;
            inCode     <= emit ? lookup.cmd : IDLE_CODE;
            codeValid  <= emit;
            frameError <= rx_err;
            if (rx_strobe) scanByte <= rx_byte;
        end
    end

endmodule

`default_nettype wire
